// File: rtl/tdc_batch_sampler.sv
// tdc_batch_sampler: launches edges into a tapped delay line, normalises and
// popcounts each returned tap vector, flags non-thermometer (bubble) captures,
// and reduces 2^LOG2_N samples into sum / mean / min / max.
// Single-batch or continuous operation, all in the clk_launch domain.
module tdc_batch_sampler #(
    parameter int TAPS    = 127,
    parameter int HW_W    = $clog2(TAPS + 1),
    parameter int LOG2_N  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_launch,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     stop,
    output logic                     pg_out,
    input  logic [TAPS-1:0]          taps_in,
    input  logic                     taps_valid,
    output logic                     busy,
    output logic                     result_valid,
    output logic [HW_W+LOG2_N-1:0]   sum_out,
    output logic [HW_W-1:0]          mean_out,
    output logic [HW_W-1:0]          min_out,
    output logic [HW_W-1:0]          max_out,
    output logic [7:0]               bubble_cnt,
    output logic                     timeout_err
);

    localparam int SUM_W = HW_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [HW_W-1:0]  HW_ONES  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Number of set taps in the normalised vector.
    function automatic logic [HW_W-1:0] popcount(input logic [TAPS-1:0] v);
        logic [HW_W-1:0] c;
        c = '0;
        for (int i = 0; i < TAPS; i++) begin
            c = c + HW_W'(v[i]);
        end
        return c;
    endfunction

    // True when v is exactly w ones packed against tap 0 (clean thermometer).
    function automatic logic is_thermo(input logic [TAPS-1:0] v, input logic [HW_W-1:0] w);
        logic [TAPS:0] one;
        logic [TAPS:0] mask;
        one  = (TAPS + 1)'(1);
        mask = (one << w) - one;
        return ({1'b0, v} == mask);
    endfunction

    // Bubble counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    state_t            state_q;
    logic              pg_q;
    logic              cont_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   wait_q;
    logic [SUM_W-1:0]  sum_q;
    logic [HW_W-1:0]   min_q;
    logic [HW_W-1:0]   max_q;
    logic [7:0]        bub_q;

    logic              res_vld_q;
    logic [SUM_W-1:0]  sum_out_q;
    logic [HW_W-1:0]   mean_out_q;
    logic [HW_W-1:0]   min_out_q;
    logic [HW_W-1:0]   max_out_q;
    logic [7:0]        bub_out_q;
    logic              terr_q;

    logic [TAPS-1:0]   norm;
    logic [HW_W-1:0]   hw;
    logic              bubble;
    logic [SUM_W-1:0]  sum_d;
    logic [HW_W-1:0]   min_d;
    logic [HW_W-1:0]   max_d;
    logic [7:0]        bub_d;

    // Accumulator values as they would be after folding in the current capture.
    always_comb begin
        // A falling launch propagates zeros, so invert to make ones mean "reached".
        norm   = pg_q ? taps_in : ~taps_in;
        hw     = popcount(norm);
        bubble = !is_thermo(norm, hw);
        sum_d  = sum_q + SUM_W'(hw);
        min_d  = (hw < min_q) ? hw : min_q;
        max_d  = (hw > max_q) ? hw : max_q;
        bub_d  = bubble ? sat_inc8(bub_q) : bub_q;
    end

    // Launch/collect state machine with accumulators and registered results.
    always_ff @(posedge clk_launch) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pg_q       <= 1'b0;
            cont_q     <= 1'b0;
            cnt_q      <= '0;
            wait_q     <= '0;
            sum_q      <= '0;
            min_q      <= HW_ONES;
            max_q      <= '0;
            bub_q      <= '0;
            res_vld_q  <= 1'b0;
            sum_out_q  <= '0;
            mean_out_q <= '0;
            min_out_q  <= '0;
            max_out_q  <= '0;
            bub_out_q  <= '0;
            terr_q     <= 1'b0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sum_q   <= '0;
                        min_q   <= HW_ONES;
                        max_q   <= '0;
                        bub_q   <= '0;
                        cnt_q   <= '0;
                        terr_q  <= 1'b0;
                        cont_q  <= continuous;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    pg_q    <= ~pg_q;
                    wait_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (taps_valid) begin
                        if (cnt_q == LAST_CNT) begin
                            // Final sample: publish results including this capture.
                            sum_out_q  <= sum_d;
                            mean_out_q <= HW_W'(sum_d >> LOG2_N);
                            min_out_q  <= min_d;
                            max_out_q  <= max_d;
                            bub_out_q  <= bub_d;
                            res_vld_q  <= 1'b1;
                            if (cont_q && !stop) begin
                                sum_q   <= '0;
                                min_q   <= HW_ONES;
                                max_q   <= '0;
                                bub_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= LAUNCH;
                            end else begin
                                cont_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            sum_q   <= sum_d;
                            min_q   <= min_d;
                            max_q   <= max_d;
                            bub_q   <= bub_d;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= LAUNCH;
                        end
                    end else if (wait_q == TO_LAST) begin
                        // No capture arrived: abort with whatever was gathered.
                        terr_q     <= 1'b1;
                        res_vld_q  <= 1'b1;
                        sum_out_q  <= sum_q;
                        mean_out_q <= HW_W'(sum_q >> LOG2_N);
                        min_out_q  <= (cnt_q == '0) ? '0 : min_q;
                        max_out_q  <= max_q;
                        bub_out_q  <= bub_q;
                        cont_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        wait_q <= wait_q + TO_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pg_out       = pg_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = res_vld_q;
    assign sum_out      = sum_out_q;
    assign mean_out     = mean_out_q;
    assign min_out      = min_out_q;
    assign max_out      = max_out_q;
    assign bubble_cnt   = bub_out_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_tdc_batch_sampler.sv
// Scoreboard bench for tdc_batch_sampler: directed batches push expected
// results into per-instance queues; monitors pop and compare on result_valid.
module tb_tdc_batch_sampler;

    localparam int TAPS = 127;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: 4-sample batches, short timeout
    logic            start_a, cont_a, stop_a, valid_a;
    logic [TAPS-1:0] taps_a;
    logic            pg_a, busy_a, rv_a, terr_a;
    logic [8:0]      sum_a;
    logic [6:0]      mean_a, min_a, max_a;
    logic [7:0]      bub_a;

    // Instance B: 256-sample batches for bubble saturation
    logic            start_b, cont_b, stop_b, valid_b;
    logic [TAPS-1:0] taps_b;
    logic            pg_b, busy_b, rv_b, terr_b;
    logic [14:0]     sum_b;
    logic [6:0]      mean_b, min_b, max_b;
    logic [7:0]      bub_b;

    tdc_batch_sampler #(.TAPS(TAPS), .LOG2_N(2), .TIMEOUT(8)) dut_a (
        .clk_launch(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a),
        .stop(stop_a), .pg_out(pg_a), .taps_in(taps_a), .taps_valid(valid_a),
        .busy(busy_a), .result_valid(rv_a), .sum_out(sum_a), .mean_out(mean_a),
        .min_out(min_a), .max_out(max_a), .bubble_cnt(bub_a), .timeout_err(terr_a)
    );

    tdc_batch_sampler #(.TAPS(TAPS), .LOG2_N(8), .TIMEOUT(8)) dut_b (
        .clk_launch(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b),
        .stop(stop_b), .pg_out(pg_b), .taps_in(taps_b), .taps_valid(valid_b),
        .busy(busy_b), .result_valid(rv_b), .sum_out(sum_b), .mean_out(mean_b),
        .min_out(min_b), .max_out(max_b), .bubble_cnt(bub_b), .timeout_err(terr_b)
    );

    typedef struct {
        int sum;
        int mean;
        int mn;
        int mx;
        int bub;
        int terr;
    } res_t;

    res_t qa[$];
    res_t qb[$];
    res_t ea, eb;

    int checks = 0;
    int errors = 0;

    logic last_pg_a, last_pg_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit b, input int s, input int m, input int mn,
                            input int mx, input int bu, input int te);
        res_t r;
        r.sum = s; r.mean = m; r.mn = mn; r.mx = mx; r.bub = bu; r.terr = te;
        if (b) qb.push_back(r);
        else   qa.push_back(r);
    endtask

    function automatic logic [TAPS-1:0] therm(input int h);
        logic [TAPS-1:0] m;
        m = '0;
        for (int i = 0; i < h; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Monitor A: every result_valid must match the oldest expected result.
    always @(negedge clk) begin
        if (rv_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_result: result_valid=1 with no result expected");
            end else begin
                ea = qa.pop_front();
                chk("a_sum",  64'(sum_a),  64'(ea.sum));
                chk("a_mean", 64'(mean_a), 64'(ea.mean));
                chk("a_min",  64'(min_a),  64'(ea.mn));
                chk("a_max",  64'(max_a),  64'(ea.mx));
                chk("a_bub",  64'(bub_a),  64'(ea.bub));
                chk("a_terr", 64'(terr_a), 64'(ea.terr));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rv_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_result: result_valid=1 with no result expected");
            end else begin
                eb = qb.pop_front();
                chk("b_sum",  64'(sum_b),  64'(eb.sum));
                chk("b_mean", 64'(mean_b), 64'(eb.mean));
                chk("b_min",  64'(min_b),  64'(eb.mn));
                chk("b_max",  64'(max_b),  64'(eb.mx));
                chk("b_bub",  64'(bub_b),  64'(eb.bub));
                chk("b_terr", 64'(terr_b), 64'(eb.terr));
            end
        end
    end

    // Wait (bounded) for the next launch toggle on the selected instance.
    task automatic wait_launch(input bit b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((b ? pg_b : pg_a) !== (b ? last_pg_b : last_pg_a)) seen = 1'b1;
        end
        chk(b ? "b_launch_seen" : "a_launch_seen", 64'(seen), 64'd1);
        if (b) last_pg_b = pg_b;
        else   last_pg_a = pg_a;
    endtask

    // mode 0: raw vector; 1: clean thermometer of weight h in launch polarity;
    // 2: normalised pattern 0b1011 in launch polarity.
    task automatic give(input bit b, input int mode, input int h, input logic [TAPS-1:0] raw);
        logic [TAPS-1:0] v;
        logic            pg;
        wait_launch(b);
        pg = b ? pg_b : pg_a;
        case (mode)
            1:       v = pg ? therm(h) : ~therm(h);
            2:       v = pg ? TAPS'(4'b1011) : ~TAPS'(4'b1011);
            default: v = raw;
        endcase
        if (b) begin taps_b = v; valid_b = 1'b1; end
        else   begin taps_a = v; valid_a = 1'b1; end
        @(negedge clk);
        if (b) valid_b = 1'b0;
        else   valid_a = 1'b0;
    endtask

    task automatic do_start(input bit b, input bit c);
        if (b) begin start_b = 1'b1; cont_b = c; end
        else   begin start_a = 1'b1; cont_a = c; end
        @(negedge clk);
        start_a = 1'b0; cont_a = 1'b0;
        start_b = 1'b0; cont_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_a = 0; cont_a = 0; stop_a = 0; valid_a = 0; taps_a = '0;
        start_b = 0; cont_b = 0; stop_b = 0; valid_b = 0; taps_b = '0;
        last_pg_a = 1'b0;
        last_pg_b = 1'b0;

        // Reset with taps_valid toggling
        repeat (3) begin
            @(negedge clk);
            valid_a = ~valid_a;
            valid_b = ~valid_b;
        end
        chk("rst_pg",    64'(pg_a),   64'd0);
        chk("rst_busy",  64'(busy_a), 64'd0);
        chk("rst_rv",    64'(rv_a),   64'd0);
        chk("rst_sum",   64'(sum_a),  64'd0);
        chk("rst_mean",  64'(mean_a), 64'd0);
        chk("rst_min",   64'(min_a),  64'd0);
        chk("rst_max",   64'(max_a),  64'd0);
        chk("rst_bub",   64'(bub_a),  64'd0);
        chk("rst_terr",  64'(terr_a), 64'd0);
        chk("rst_b_busy", 64'(busy_b), 64'd0);
        chk("rst_b_pg",   64'(pg_b),   64'd0);
        valid_a = 1'b0;
        valid_b = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // Single batch of clean thermometer codes: 10,12,11,13
        push_exp(0, 46, 11, 10, 13, 0, 0);
        do_start(0, 0);
        chk("start_busy", 64'(busy_a), 64'd1);
        give(0, 1, 10, '0);
        give(0, 1, 12, '0);
        give(0, 1, 11, '0);
        give(0, 1, 13, '0);
        chk("single_idle", 64'(busy_a), 64'd0);
        repeat (3) @(negedge clk);
        chk("single_no_relaunch", 64'(pg_a), 64'(last_pg_a));

        // Polarity: ~therm(12) is clean at pg=0, bubbly hw=115 at pg=1
        push_exp(0, 142, 35, 5, 115, 1, 0);
        do_start(0, 0);
        give(0, 1, 10, '0);
        give(0, 0, 0, ~therm(12));
        give(0, 0, 0, ~therm(12));
        give(0, 1, 5, '0);

        // Bubble pattern in both polarities, plus the empty and full extremes
        push_exp(0, 133, 33, 0, 127, 2, 0);
        do_start(0, 0);
        give(0, 0, 0, TAPS'(4'b1011));
        give(0, 0, 0, ~TAPS'(4'b1011));
        give(0, 1, 0, '0);
        give(0, 1, 127, '0);

        // Timeout after two samples
        push_exp(0, 50, 12, 20, 30, 0, 1);
        do_start(0, 0);
        give(0, 1, 20, '0);
        give(0, 1, 30, '0);
        wait_launch(0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("timeout_not_early", 64'(rv_a), 64'd0);
        end
        @(negedge clk);
        chk("timeout_rv", 64'(rv_a), 64'd1);
        chk("timeout_err_set", 64'(terr_a), 64'd1);
        @(negedge clk);
        chk("timeout_idle", 64'(busy_a), 64'd0);
        chk("timeout_sticky", 64'(terr_a), 64'd1);

        // Next start clears timeout_err; zero-sample timeout reports min 0
        push_exp(0, 0, 0, 0, 0, 0, 1);
        do_start(0, 0);
        chk("start_clears_terr", 64'(terr_a), 64'd0);
        wait_launch(0);
        repeat (9) @(negedge clk);
        chk("empty_timeout_idle", 64'(busy_a), 64'd0);

        // Continuous: two batches back-to-back, start ignored while busy, stop at boundary
        push_exp(0, 10, 2, 1, 4, 0, 0);
        push_exp(0, 26, 6, 5, 8, 0, 0);
        do_start(0, 1);
        give(0, 1, 1, '0);
        give(0, 1, 2, '0);
        give(0, 1, 3, '0);
        give(0, 1, 4, '0);
        chk("cont_busy", 64'(busy_a), 64'd1);
        @(negedge clk);
        chk("cont_no_gap", 64'(pg_a), 64'(!last_pg_a));
        give(0, 1, 5, '0);
        give(0, 1, 6, '0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b1;
        give(0, 1, 7, '0);
        give(0, 1, 8, '0);
        stop_a  = 1'b0;
        chk("stop_idle", 64'(busy_a), 64'd0);
        repeat (3) @(negedge clk);
        chk("stop_no_relaunch", 64'(pg_a), 64'(last_pg_a));

        // Reset in the middle of WAIT
        do_start(0, 0);
        give(0, 1, 9, '0);
        wait_launch(0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_pg",   64'(pg_a),   64'd0);
        chk("midrst_sum",  64'(sum_a),  64'd0);
        chk("midrst_max",  64'(max_a),  64'd0);
        chk("midrst_rv",   64'(rv_a),   64'd0);
        rst_n = 1'b1;
        last_pg_a = 1'b0;
        @(negedge clk);

        // 300 bubbly samples in continuous mode: 256-sample batch saturates,
        // then the partial second batch ends by timeout
        push_exp(1, 768, 3, 3, 3, 255, 0);
        push_exp(1, 132, 0, 3, 3, 44, 1);
        do_start(1, 1);
        for (int i = 0; i < 300; i++) give(1, 2, 0, '0);
        wait_launch(1);
        repeat (9) @(negedge clk);
        chk("b_idle", 64'(busy_b), 64'd0);

        repeat (3) @(negedge clk);
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
